// File: rtl/traffic_pkg.sv
// Shared encodings for the A/B traffic light controller: lamp codes and phase codes.
package traffic_pkg;

    typedef enum logic [1:0] {
        S_AG = 2'd0,
        S_AY = 2'd1,
        S_BG = 2'd2,
        S_BY = 2'd3
    } phase_e;

    localparam logic [1:0] LAMP_GREEN  = 2'b00;
    localparam logic [1:0] LAMP_YELLOW = 2'b01;
    localparam logic [1:0] LAMP_RED    = 2'b10;

endpackage

// File: rtl/phase_timer.sv
// Phase duration counter: clears synchronously on request, otherwise counts up and
// saturates at all-ones so a long-held phase never wraps back to "first cycle".
module phase_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cnt_q <= '0;
        end else if (i_clr) begin
            cnt_q <= '0;
        end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign o_cnt = cnt_q;

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-street traffic light sequencer with minimum/maximum green, fixed yellow and a
// parade mode that holds street B green. Lamps are decoded from the phase register only.
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned YELLOW_CYC    = 5,
    parameter int unsigned MIN_GREEN_CYC = 10,
    parameter int unsigned MAX_GREEN_CYC = 60,
    parameter int unsigned CNT_W         = 8
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_TA,
    input  logic       i_TB,
    input  logic       i_M,
    output logic [1:0] o_LA,
    output logic [1:0] o_LB,
    output logic [1:0] o_state
);

    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(MIN_GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] MAX_LAST    = CNT_W'(MAX_GREEN_CYC - 1);

    logic             ta_r, tb_r, m_r;
    phase_e           state_q, state_d;
    logic [CNT_W-1:0] cnt;
    logic             phase_change;

    // Decisions only ever see these registered copies of the inputs.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            ta_r    <= 1'b0;
            tb_r    <= 1'b0;
            m_r     <= 1'b0;
            state_q <= S_AG;
        end else begin
            ta_r    <= i_TA;
            tb_r    <= i_TB;
            m_r     <= i_M;
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_AG: begin
                if (cnt >= MIN_LAST && (m_r || !ta_r || (tb_r && cnt >= MAX_LAST))) begin
                    state_d = S_AY;
                end
            end
            S_AY: begin
                if (cnt == YELLOW_LAST) begin
                    state_d = S_BG;
                end
            end
            S_BG: begin
                if (cnt >= MIN_LAST && !m_r && (!tb_r || (ta_r && cnt >= MAX_LAST))) begin
                    state_d = S_BY;
                end
            end
            S_BY: begin
                if (cnt == YELLOW_LAST) begin
                    state_d = S_AG;
                end
            end
        endcase
    end

    assign phase_change = (state_d != state_q);

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_phase_timer (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_clr  (phase_change),
        .o_cnt  (cnt)
    );

    always_comb begin
        o_LA = LAMP_RED;
        o_LB = LAMP_RED;
        unique case (state_q)
            S_AG: o_LA = LAMP_GREEN;
            S_AY: o_LA = LAMP_YELLOW;
            S_BG: o_LB = LAMP_GREEN;
            S_BY: o_LB = LAMP_YELLOW;
        endcase
    end

    assign o_state = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboard bench: stimulus pushes the hand-derived phase for each cycle, monitors
// pop and compare phase and lamps on the falling clock edge and on async reset.
module tb_traffic_light_ctrl;
    import traffic_pkg::*;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic       ta   = 1'b0;
    logic       tb   = 1'b0;
    logic       m    = 1'b0;
    logic [1:0] la, lb, st;

    logic [1:0] exp_q[$];
    logic [1:0] rst_exp_q[$];
    logic [1:0] mon_exp;
    logic [1:0] rst_exp;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    traffic_light_ctrl dut (
        .i_clk   (clk),
        .i_rstn  (rstn),
        .i_TA    (ta),
        .i_TB    (tb),
        .i_M     (m),
        .o_LA    (la),
        .o_LB    (lb),
        .o_state (st)
    );

    function automatic logic [1:0] lamp_a(input logic [1:0] p);
        case (p)
            2'd0:    return LAMP_GREEN;
            2'd1:    return LAMP_YELLOW;
            default: return LAMP_RED;
        endcase
    endfunction

    function automatic logic [1:0] lamp_b(input logic [1:0] p);
        case (p)
            2'd2:    return LAMP_GREEN;
            2'd3:    return LAMP_YELLOW;
            default: return LAMP_RED;
        endcase
    endfunction

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b, want %b at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rstn && exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            check("state", st, mon_exp);
            check("lamp_a", la, lamp_a(mon_exp));
            check("lamp_b", lb, lamp_b(mon_exp));
            checks++;
            if (la != LAMP_RED && lb != LAMP_RED) begin
                errors++;
                $display("FAIL conflict: la=%b lb=%b, want one red at %0t", la, lb, $time);
            end
        end
    end

    always @(negedge rstn) begin
        #1;
        if (rst_exp_q.size() > 0) begin
            rst_exp = rst_exp_q.pop_front();
            check("rst_state", st, rst_exp);
            check("rst_lamp_a", la, lamp_a(rst_exp));
            check("rst_lamp_b", lb, lamp_b(rst_exp));
        end
    end

    // One cycle: record expected phase, drive inputs, advance to just after the next edge.
    task automatic cyc(input logic ta_v, input logic tb_v, input logic m_v,
                       input logic [1:0] e);
        exp_q.push_back(e);
        ta = ta_v;
        tb = tb_v;
        m  = m_v;
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;

        // A busy, B empty: A stays green.
        for (int n = 0; n < 200; n++) cyc(1'b1, 1'b0, 1'b0, S_AG);

        // A traffic clears at cycle 30 with B waiting.
        restart();
        for (int n = 0; n < 30; n++) cyc(1'b1, 1'b1, 1'b0, S_AG);
        for (int n = 30; n < 32; n++) cyc(1'b0, 1'b1, 1'b0, S_AG);
        for (int n = 32; n < 37; n++) cyc(1'b0, 1'b1, 1'b0, S_AY);
        for (int n = 37; n < 60; n++) cyc(1'b0, 1'b1, 1'b0, S_BG);

        // Both streets busy: max-green alternation, period 130.
        restart();
        for (int n = 0; n < 260; n++) begin
            int r;
            r = n % 130;
            if (r < 60)       cyc(1'b1, 1'b1, 1'b0, S_AG);
            else if (r < 65)  cyc(1'b1, 1'b1, 1'b0, S_AY);
            else if (r < 125) cyc(1'b1, 1'b1, 1'b0, S_BG);
            else              cyc(1'b1, 1'b1, 1'b0, S_BY);
        end

        // No traffic: min-green alternation, period 30.
        restart();
        for (int n = 0; n < 60; n++) begin
            int r;
            r = n % 30;
            if (r < 10)      cyc(1'b0, 1'b0, 1'b0, S_AG);
            else if (r < 15) cyc(1'b0, 1'b0, 1'b0, S_AY);
            else if (r < 25) cyc(1'b0, 1'b0, 1'b0, S_BG);
            else             cyc(1'b0, 1'b0, 1'b0, S_BY);
        end

        // Parade mode from cycle 20, held 500 cycles of B green, then released.
        restart();
        for (int n = 0; n < 20; n++) cyc(1'b1, 1'b0, 1'b0, S_AG);
        for (int n = 20; n < 22; n++) cyc(1'b1, 1'b0, 1'b1, S_AG);
        for (int n = 22; n < 27; n++) cyc(1'b1, 1'b0, 1'b1, S_AY);
        for (int n = 27; n < 527; n++) cyc(1'b1, 1'b0, 1'b1, S_BG);
        for (int n = 527; n < 529; n++) cyc(1'b1, 1'b0, 1'b0, S_BG);
        for (int n = 529; n < 534; n++) cyc(1'b1, 1'b0, 1'b0, S_BY);
        for (int n = 534; n < 546; n++) cyc(1'b1, 1'b0, 1'b0, S_AG);

        // Async reset in the middle of A yellow, then min green after release.
        restart();
        for (int n = 0; n < 30; n++) cyc(1'b1, 1'b1, 1'b0, S_AG);
        for (int n = 30; n < 32; n++) cyc(1'b0, 1'b1, 1'b0, S_AG);
        for (int n = 32; n < 34; n++) cyc(1'b0, 1'b1, 1'b0, S_AY);
        exp_q.push_back(S_AY);
        @(negedge clk);
        #2;
        rst_exp_q.push_back(S_AG);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int n = 0; n < 10; n++) cyc(1'b0, 1'b0, 1'b0, S_AG);
        for (int n = 10; n < 15; n++) cyc(1'b0, 1'b0, 1'b0, S_AY);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0 || rst_exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d/%0d entries left, want 0", exp_q.size(), rst_exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
